// File: rtl/dprintf_pkg.sv
// Shared dprintf definitions: default widths, the request record and a one-hot index helper.
package dprintf_pkg;

  localparam int unsigned DPRINTF_NUM_PORTS  = 4;
  localparam int unsigned DPRINTF_ADDR_WIDTH = 16;
  localparam int unsigned DPRINTF_DATA_WIDTH = 64;

  typedef struct packed {
    logic                          valid;
    logic [DPRINTF_ADDR_WIDTH-1:0] address;
    logic [DPRINTF_DATA_WIDTH-1:0] data_0;
    logic [DPRINTF_DATA_WIDTH-1:0] data_1;
  } dprintf_req_t;

  // Index of the set bit in a one-hot vector of up to 8 requesters.
  function automatic logic [2:0] onehot_to_index(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (onehot[3'(i)]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dprintf_arbiter_mux_if.sv
// Request/ack bundle between the dprintf requesters, the merger and the downstream consumer.
interface dprintf_arbiter_mux_if
  import dprintf_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = DPRINTF_NUM_PORTS,
  parameter int unsigned ADDR_WIDTH = DPRINTF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DPRINTF_DATA_WIDTH
);

  logic [NUM_PORTS-1:0]            req_in__valid;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_in__address;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_in__data_0;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_in__data_1;
  logic [NUM_PORTS-1:0]            ack_in;
  logic                            req__valid;
  logic [ADDR_WIDTH-1:0]           req__address;
  logic [DATA_WIDTH-1:0]           req__data_0;
  logic [DATA_WIDTH-1:0]           req__data_1;
  logic                            ack;

  modport master (
    output req_in__valid, req_in__address, req_in__data_0, req_in__data_1, ack,
    input  ack_in, req__valid, req__address, req__data_0, req__data_1
  );

  modport slave (
    input  req_in__valid, req_in__address, req_in__data_0, req_in__data_1, ack,
    output ack_in, req__valid, req__address, req__data_0, req__data_1
  );

endinterface

// File: rtl/dprintf_rr_arbiter.sv
// Combinational grant selection: round-robin after ptr, or lowest index when
// DPRINTF_ARBITER_MUX_FIXED_PRIORITY_EN is defined.
module dprintf_rr_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned PTR_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] eligible,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] grant
);

`ifdef DPRINTF_ARBITER_MUX_FIXED_PRIORITY_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Isolate the lowest set bit.
  assign grant = eligible & (~eligible + NUM_PORTS'(1));
`else
  // Scan starting at the port after the last grant, wrapping at NUM_PORTS.
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      idx = PTR_W'((32'(ptr) + k) % NUM_PORTS);
      if (!found && eligible[idx]) begin
        grant = NUM_PORTS'(1) << idx;
        found = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/dprintf_arbiter_mux.sv
// Merges NUM_PORTS dprintf requesters into one stream through a 2-entry FIFO.
// Define DPRINTF_ARBITER_MUX_FIXED_PRIORITY_EN for lowest-index-wins arbitration.
module dprintf_arbiter_mux
  import dprintf_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = DPRINTF_NUM_PORTS,
  parameter int unsigned ADDR_WIDTH = DPRINTF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DPRINTF_DATA_WIDTH
) (
  input logic                  clk,
  input logic                  reset_n,
  input logic                  clk__enable,
  dprintf_arbiter_mux_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(NUM_PORTS);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_0;
    logic [DATA_WIDTH-1:0] data_1;
  } entry_t;

  logic [1:0]           count, count_n;
  entry_t               head, head_n, tail, tail_n;
  entry_t               grant_entry;
  logic [PTR_W-1:0]     ptr, sel;
  logic [NUM_PORTS-1:0] eligible, candidate, grant;
  logic                 pop, take, push;

  logic [ADDR_WIDTH-1:0] port_addr [NUM_PORTS];
  logic [DATA_WIDTH-1:0] port_d0   [NUM_PORTS];
  logic [DATA_WIDTH-1:0] port_d1   [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign port_addr[g] = bus.req_in__address[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign port_d0[g]   = bus.req_in__data_0[g*DATA_WIDTH +: DATA_WIDTH];
    assign port_d1[g]   = bus.req_in__data_1[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // A port just acked is still holding valid for this cycle; mask it.
  assign eligible = bus.req_in__valid & ~bus.ack_in;
  assign pop      = bus.ack & bus.req__valid;
  assign take     = (count != 2'd2) || pop;

  dprintf_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_arb (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (candidate)
  );

  assign grant       = take ? candidate : '0;
  assign push        = |grant;
  assign sel         = PTR_W'(onehot_to_index(8'(candidate)));
  assign grant_entry = '{address: port_addr[sel], data_0: port_d0[sel], data_1: port_d1[sel]};

  // FIFO next state: pop shifts tail into head, push fills the first free slot.
  always_comb begin
    count_n = count;
    head_n  = head;
    tail_n  = tail;
    if (pop) begin
      head_n  = tail;
      count_n = count - 2'd1;
    end
    if (push) begin
      if (count_n == 2'd0) head_n = grant_entry;
      else                 tail_n = grant_entry;
      count_n = count_n + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count          <= '0;
      head           <= '0;
      tail           <= '0;
      ptr            <= PTR_W'(NUM_PORTS - 1);
      bus.ack_in     <= '0;
      bus.req__valid <= 1'b0;
    end else if (clk__enable) begin
      count          <= count_n;
      head           <= head_n;
      tail           <= tail_n;
      bus.ack_in     <= grant;
      bus.req__valid <= (count_n != 2'd0);
      if (push) ptr <= sel;
    end
  end

  assign bus.req__address = head.address;
  assign bus.req__data_0  = head.data_0;
  assign bus.req__data_1  = head.data_1;

endmodule

// File: tb/tb_dprintf_arbiter_mux.sv
// Directed self-checking bench for dprintf_arbiter_mux (4 ports, default widths).
module tb_dprintf_arbiter_mux;
  import dprintf_pkg::*;

  localparam int unsigned NP = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 64;

  logic clk = 1'b0;
  logic reset_n;
  logic clk__enable;
  int   errors = 0;
  int   checks = 0;

  dprintf_req_t vec [NP];

  always #5 clk = ~clk;

  dprintf_arbiter_mux_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dprintf_arbiter_mux #(
    .NUM_PORTS  (NP),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clk__enable (clk__enable),
    .bus         (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] ack_exp, input logic vld_exp,
                           input logic [15:0] addr_exp);
    check({tag, "_ack_in"}, 64'(bus.ack_in), 64'(ack_exp));
    check({tag, "_valid"}, 64'(bus.req__valid), 64'(vld_exp));
    if (vld_exp) check({tag, "_addr"}, 64'(bus.req__address), 64'(addr_exp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [1:0] p;
    for (int i = 0; i < 4; i++) begin
      vec[2'(i)].valid   = 1'b1;
      vec[2'(i)].address = 16'h0010 + 16'(i) * 16'h0100;
      vec[2'(i)].data_0  = 64'hD000_0000_0000_0000 + 64'(i);
      vec[2'(i)].data_1  = 64'h1111_2222_0000_0000 + 64'(i);
    end
    reset_n              = 1'b0;
    clk__enable          = 1'b1;
    bus.ack              = 1'b0;
    bus.req_in__valid    = '0;
    bus.req_in__address  = {vec[3].address, vec[2].address, vec[1].address, vec[0].address};
    bus.req_in__data_0   = {vec[3].data_0, vec[2].data_0, vec[1].data_0, vec[0].data_0};
    bus.req_in__data_1   = {vec[3].data_1, vec[2].data_1, vec[1].data_1, vec[0].data_1};

    // Reset values
    #12;
    check("rst_valid", 64'(bus.req__valid), 64'd0);
    check("rst_ack_in", 64'(bus.ack_in), 64'd0);
    check("rst_addr", 64'(bus.req__address), 64'd0);
    check("rst_d0", bus.req__data_0, 64'd0);
    check("rst_d1", bus.req__data_1, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // First request after reset: port 0, latency 1
    bus.req_in__valid = 4'b0001;
    step();
    check_out("first", 4'b0001, 1'b1, 16'h0010);
    check("first_d0", bus.req__data_0, vec[0].data_0);
    bus.req_in__valid = 4'b0000;
    step();
    check_out("first_hold", 4'b0000, 1'b1, 16'h0010);
    bus.ack = 1'b1;
    step();
    check_out("first_pop", 4'b0000, 1'b0, 16'h0000);
    bus.ack = 1'b0;

    do_reset();
`ifdef DPRINTF_ARBITER_MUX_FIXED_PRIORITY_EN
    // Ports 1 and 3 always valid: port 1 wins whenever it is not masked by its ack
    bus.ack           = 1'b1;
    bus.req_in__valid = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      p = (k % 2 == 0) ? 2'd1 : 2'd3;
      step();
      check_out($sformatf("fixed_%0d", k), 4'b0001 << p, 1'b1, vec[p].address);
    end
`else
    // All ports valid with ack held high: 0,1,2,3,0,1 one per cycle
    bus.ack           = 1'b1;
    bus.req_in__valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      p = 2'(k % 4);
      step();
      check_out($sformatf("rr_%0d", k), 4'b0001 << p, 1'b1, vec[p].address);
    end
`endif
    bus.req_in__valid = 4'b0000;
    step();
    check_out("rr_drain", 4'b0000, 1'b0, 16'h0000);
    bus.ack = 1'b0;

    // Back-pressure: two grants fill the FIFO, third requester waits
    do_reset();
    bus.req_in__valid = 4'b0011;
    step();
    check_out("bp_g0", 4'b0001, 1'b1, vec[0].address);
    bus.req_in__valid = 4'b0110;
    step();
    check_out("bp_g1", 4'b0010, 1'b1, vec[0].address);
    bus.req_in__valid = 4'b0100;
    step();
    check_out("bp_full", 4'b0000, 1'b1, vec[0].address);
    step();
    check_out("bp_full2", 4'b0000, 1'b1, vec[0].address);
    check("bp_full2_d1", bus.req__data_1, vec[0].data_1);

    // Full FIFO with ack: pop and push in the same cycle
    bus.ack = 1'b1;
    step();
    check_out("full_swap", 4'b0100, 1'b1, vec[1].address);
    check("full_swap_d1", bus.req__data_1, vec[1].data_1);
    bus.req_in__valid = 4'b0000;
    step();
    check_out("full_next", 4'b0000, 1'b1, vec[2].address);
    check("full_next_d0", bus.req__data_0, vec[2].data_0);
    step();
    check_out("full_drain", 4'b0000, 1'b0, 16'h0000);
    bus.ack = 1'b0;

    // Mid-operation reset with two buffered entries
    bus.req_in__valid = 4'b0011;
    step();
    check_out("mid_g0", 4'b0001, 1'b1, vec[0].address);
    bus.req_in__valid = 4'b0010;
    step();
    check_out("mid_g1", 4'b0010, 1'b1, vec[0].address);
    bus.req_in__valid = 4'b0000;
    reset_n           = 1'b0;
    #2;
    check_out("mid_rst", 4'b0000, 1'b0, 16'h0000);
    check("mid_rst_addr", 64'(bus.req__address), 64'd0);
    step();
    reset_n = 1'b1;
    step();
    check_out("post_rst", 4'b0000, 1'b0, 16'h0000);
    step();
    check_out("post_rst2", 4'b0000, 1'b0, 16'h0000);

    // Clock enable low freezes everything
    clk__enable       = 1'b0;
    bus.req_in__valid = 4'b0001;
    step();
    check_out("en_low", 4'b0000, 1'b0, 16'h0000);
    step();
    check_out("en_low2", 4'b0000, 1'b0, 16'h0000);
    clk__enable = 1'b1;
    step();
    check_out("en_high", 4'b0001, 1'b1, vec[0].address);
    bus.req_in__valid = 4'b0000;
    bus.ack           = 1'b1;
    step();
    check_out("en_drain", 4'b0000, 1'b0, 16'h0000);
    bus.ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dprintf_arbiter_mux.md
DPRINTF_ARBITER_MUX -- requirements
Module: dprintf_arbiter_mux

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of dprintf requesters, legal range 2..8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, dprintf address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, width of each of data_0/data_1.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  in  1  sole clock, rising edge; reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have clk__enable  in  1  clock enable; no state changes when low.
REQ-006 SHALL have req_in__valid  in  NUM_PORTS  per-port request valid, held until acked.
REQ-007 SHALL have req_in__address  in  NUM_PORTS*ADDR_WIDTH  per-port address, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 SHALL have req_in__data_0 / req_in__data_1  in  NUM_PORTS*DATA_WIDTH each  per-port data, same packing.
REQ-009 SHALL have ack_in  out  NUM_PORTS  per-port one-cycle ack pulse.
REQ-010 SHALL have req__valid, req__address, req__data_0, req__data_1  out  1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH  merged request, all registered.
REQ-011 SHALL have ack  in  1  downstream acceptance of the current merged request.

Function
REQ-012 SHALL hold accepted requests in a 2-entry output FIFO; the head drives req__*; req__valid = FIFO non-empty.
REQ-013 SHALL treat ack as a pop only while req__valid is 1; ack with req__valid 0 SHALL be ignored.
REQ-014 SHALL permit a take in a cycle iff FIFO count < 2, or count = 2 and ack = 1 (simultaneous pop and push).
REQ-015 SHALL treat port i as eligible iff req_in__valid[i] = 1 and ack_in[i] = 0.
REQ-016 SHALL grant at most one eligible port per permitted cycle, round-robin starting at the port after the last granted port.
REQ-017 SHALL assert ack_in[i] for exactly one cycle, in the cycle after port i is granted; never for two ports at once.
REQ-018 SHALL push the granted port's address/data in the grant cycle; with an empty FIFO req__valid rises the next cycle (latency 1).
REQ-019 SHALL sustain one grant and one pop per cycle when ack is continuously 1 and eligible ports exist.
REQ-020 SHALL keep req__* stable while req__valid = 1 and ack = 0.
REQ-021 SHALL preserve grant order in the FIFO; wrap of the round-robin pointer from NUM_PORTS-1 to 0 SHALL be seamless.
REQ-022 SHALL update the round-robin pointer only on a grant.

Reset
REQ-023 SHALL, on reset_n low, asynchronously clear FIFO count, ack_in, req__valid, req__address, req__data_0 and req__data_1 to 0.
REQ-024 SHALL reset the round-robin pointer to NUM_PORTS-1 so port 0 has first priority.
REQ-025 SHALL discard any buffered request on reset mid-operation; no ack_in SHALL be issued after reset deassertion for pre-reset grants.

Configuration
REQ-026 SHALL, with DPRINTF_ARBITER_MUX_FIXED_PRIORITY_EN defined, grant the lowest-index eligible port and not use the round-robin pointer.
REQ-027 SHALL, without DPRINTF_ARBITER_MUX_FIXED_PRIORITY_EN, use round-robin as in REQ-016.

Structure
REQ-028 SHALL take the dprintf request record type (valid, address, data_0, data_1) and default widths from shared package dprintf_pkg.
REQ-029 SHALL place grant selection in sub-module dprintf_rr_arbiter (eligible mask + pointer in, one-hot grant out, combinational).

Verification
REQ-030 Reset: reset_n low then high -> all outputs 0; first request on port 0 address 0x0010 -> ack_in = 0001 next cycle, req__address = 0x0010.
REQ-031 Fairness: NUM_PORTS=4, all ports valid continuously, ack = 1 -> grant order 0,1,2,3,0,... one per cycle.
REQ-032 Back-pressure: ack = 0, ports 0 and 1 valid -> two grants, third requester waits; req__* held at first request until ack.
REQ-033 Full simultaneous: FIFO count 2, ack = 1, port 2 valid -> pop and push same cycle, ack_in[2] next cycle, count stays 2.
REQ-034 Fixed priority (macro defined): ports 1 and 3 continuously valid, ack = 1 -> port 1 granted whenever eligible.
REQ-035 Mid-operation reset: FIFO holding two entries, reset_n pulsed -> req__valid 0, no stale ack_in after release.
